frame_counter: RTL and testbench
================================

Name: frame_counter

Overview:
- APU frame sequencer. It generates the quarter-frame and half-frame clock pulses that drive the envelope, linear-counter, length-counter and sweep units of the pulse, triangle and noise channels.
- It also generates the frame IRQ.
- Those channels produce the 4-bit waves summed by the APU mixer, so this block schedules every amplitude/length update that reaches the mixer.
- Configuration comes from CPU writes to $4017. The IRQ flag is acknowledged via $4015 reads.

Parameters:
- RESET_DELAY, 3: number of cpu_ce ticks between a $4017 write and the sequencer counter reset (range 1..7).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cpu_ce  input  1  CPU-cycle enable, one clk wide per CPU cycle
- wr_4017  input  1  write strobe for $4017, one clk wide
- wr_data  input  8  CPU write data; bit7 = mode (1 = 5-step), bit6 = IRQ inhibit
- irq_ack  input  1  $4015 read strobe, clears the frame IRQ flag
- quarter_frame  output  1  one-clk pulse, clocks envelopes and the triangle linear counter
- half_frame  output  1  one-clk pulse, clocks length counters and sweeps
- frame_irq  output  1  frame IRQ flag, level
- mode_5step  output  1  current mode, for the $4015/status logic

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values:
  - step counter c = 0; mode = 0; inhibit = 0; frame_irq = 0
  - quarter_frame = 0; half_frame = 0; mode_5step = 0
  - no write pending
- Step counter: 16-bit c, advanced only on clk edges with cpu_ce = 1. On such an edge, events are decoded from the current c and registered, so pulses appear on the following clk for exactly one clk. Then c <= (c == LAST) ? 0 : c + 1.
- 4-step mode (mode = 0), LAST = 29829, period 29830:
  - c = 7457: quarter
  - c = 14913: quarter + half
  - c = 22371: quarter
  - c = 29828: IRQ set
  - c = 29829: quarter + half + IRQ set
- 5-step mode (mode = 1), LAST = 37281, period 37282:
  - c = 7457: quarter
  - c = 14913: quarter + half
  - c = 22371: quarter
  - c = 37281: quarter + half
  - no IRQ sets in this mode
- IRQ set: frame_irq <= 1 only if inhibit = 0.
- IRQ clear:
  - irq_ack clears frame_irq on any clk.
  - A $4017 write with bit6 = 1 clears frame_irq on the next clk.
  - Simultaneous set and ack: set wins.
- $4017 write, captured on any clk with wr_4017 = 1, regardless of cpu_ce:
  - mode and inhibit update on the next clk; mode_5step follows mode.
  - A reset-delay counter loads RESET_DELAY. It decrements on each subsequent cpu_ce tick; the tick coinciding with the write does not count.
  - While the delay is pending, c keeps counting and its events fire, decoded with the new mode.
  - When the delay reaches 0, on that cpu_ce tick: c <= 0 and the normal decode is suppressed. If mode = 1, quarter + half pulses are emitted.
  - A second write while pending reloads the delay and latches the new data. The last write wins.
- cpu_ce = 0: c, the delay counter and event pulses are frozen. Only IRQ clearing and write capture operate.
- Reset asserted mid-frame or mid-delay: everything returns to the reset values on that edge. The pending reset is discarded and no pulses are emitted.
- quarter_frame and half_frame are never high for more than one consecutive clk.

Optional Feature:
- Macro: FRAME_COUNTER_PAL_EN.
- When defined, PAL (2A07) step values are used:
  - 4-step events at 8313, 16627, 24939, 33252 (quarter + half + IRQ); IRQ also at 33251; LAST = 33252.
  - 5-step events at 8313, 16627, 24939, 41565; LAST = 41565.
- When undefined, the NTSC values above apply.
- Ports and all other behaviour are identical in both builds.

Test Plan:
1. Reset, then cpu_ce every clk, no writes:
   - quarter pulses at ticks 7457, 14913, 22371, 29829; half pulses at 14913 and 29829.
   - frame_irq rises after tick 29828 and stays high; the pattern repeats with period 29830.
2. frame_irq high, pulse irq_ack → frame_irq = 0 next clk. Drive irq_ack in the same clk as the tick-29828 set → frame_irq = 1.
3. Write 0x40 at c = 1000 → frame_irq cleared; no IRQ at 29828/29829; quarter/half pulses still occur.
4. Write 0x80 at c = 5000, RESET_DELAY = 3:
   - after 3 further ticks, quarter + half pulse together and c = 0.
   - next quarter 7457 ticks later; half at 14913 and 37281; frame_irq never set.
5. Two writes (0x80, then 0x00) 1 tick apart → only one counter reset, 3 ticks after the second write, with no immediate pulse (mode 0). Assert reset during a pending delay → no pulse, c = 0.
6. FRAME_COUNTER_PAL_EN build, scenario 1 → quarter at 8313, 16627, 24939, 33252; IRQ from tick 33251; period 33253.

Source files
------------

// File: rtl/frame_counter.sv
// APU frame sequencer: quarter/half-frame clock pulses and the frame IRQ, configured by $4017.
// Define FRAME_COUNTER_PAL_EN for 2A07 (PAL) step values; NTSC timing otherwise.
module frame_counter #(
  parameter int RESET_DELAY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_ce,
  input  logic       wr_4017,
  input  logic [7:0] wr_data,
  input  logic       irq_ack,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic       mode_5step
);

`ifdef FRAME_COUNTER_PAL_EN
  localparam logic [15:0] STEP1  = 16'd8313;
  localparam logic [15:0] STEP2  = 16'd16627;
  localparam logic [15:0] STEP3  = 16'd24939;
  localparam logic [15:0] LAST4  = 16'd33252;
  localparam logic [15:0] LAST5  = 16'd41565;
`else
  localparam logic [15:0] STEP1  = 16'd7457;
  localparam logic [15:0] STEP2  = 16'd14913;
  localparam logic [15:0] STEP3  = 16'd22371;
  localparam logic [15:0] LAST4  = 16'd29829;
  localparam logic [15:0] LAST5  = 16'd37281;
`endif

  logic [15:0] c;
  logic        mode;
  logic        inhibit;
  logic [2:0]  dly;

  logic [15:0] last;
  logic        ev_q, ev_h, ev_irq;
  logic        fire;
  logic        unused_wr_bits;

  assign unused_wr_bits = ^wr_data[5:0];
  assign mode_5step     = mode;

  always_comb begin
    last   = mode ? LAST5 : LAST4;
    ev_h   = (c == STEP2) || (c == last);
    ev_q   = (c == STEP1) || (c == STEP3) || ev_h;
    ev_irq = !mode && ((c == LAST4 - 16'd1) || (c == LAST4));
  end

  // A write landing on the expiring tick reloads the delay instead of firing.
  assign fire = cpu_ce && (dly == 3'd1) && !wr_4017;

  always_ff @(posedge clk) begin
    if (reset) begin
      c             <= '0;
      mode          <= 1'b0;
      inhibit       <= 1'b0;
      dly           <= '0;
      frame_irq     <= 1'b0;
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
    end else begin
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;

      if (fire) begin
        c             <= '0;
        dly           <= '0;
        // Gate on the current pulse so a fire right after a decoded event
        // never stretches a pulse to two clks.
        quarter_frame <= mode && !quarter_frame;
        half_frame    <= mode && !half_frame;
      end else if (cpu_ce) begin
        c             <= (c == last) ? '0 : c + 16'd1;
        quarter_frame <= ev_q && !quarter_frame;
        half_frame    <= ev_h && !half_frame;
        if (dly != 3'd0 && !wr_4017)
          dly <= dly - 3'd1;
      end

      if (irq_ack || (wr_4017 && wr_data[6]))
        frame_irq <= 1'b0;
      if (cpu_ce && !fire && ev_irq && !inhibit)
        frame_irq <= 1'b1;

      if (wr_4017) begin
        mode    <= wr_data[7];
        inhibit <= wr_data[6];
        dly     <= 3'(RESET_DELAY);
      end
    end
  end

endmodule

// File: tb/tb_frame_counter.sv
// Bench for frame_counter: reset vector table, pending-reset corner cases, and long runs
// checked every clk against a step-rule reference model.
module tb_frame_counter;
  localparam int RD = 3;
`ifdef FRAME_COUNTER_PAL_EN
  localparam int S1 = 8313, S2 = 16627, S3 = 24939, L4 = 33252, L5 = 41565;
`else
  localparam int S1 = 7457, S2 = 14913, S3 = 22371, L4 = 29829, L5 = 37281;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_ce = 1'b0;
  logic       wr_4017 = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       irq_ack = 1'b0;
  logic       quarter_frame, half_frame, frame_irq, mode_5step;

  always #5 clk = ~clk;

  frame_counter #(.RESET_DELAY(RD)) dut (
    .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .wr_4017(wr_4017), .wr_data(wr_data),
    .irq_ack(irq_ack), .quarter_frame(quarter_frame), .half_frame(half_frame),
    .frame_irq(frame_irq), .mode_5step(mode_5step)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_c = 0, m_pend = 0;
  bit m_mode = 0, m_inh = 0, m_irq = 0, m_q = 0, m_h = 0;

  typedef struct {
    bit         ce;
    bit         wr;
    logic [7:0] d;
    bit         ack;
    bit         q, h, irq, mode;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b (model c=%0d)", name, $time, act, exp, m_c);
    end
  endtask

  function automatic void events(input int cc, input bit m, output bit q, output bit h, output bit ir);
    int last;
    last = m ? L5 : L4;
    h  = (cc == S2) || (cc == last);
    q  = h || (cc == S1) || (cc == S3);
    ir = !m && (cc == L4 - 1 || cc == L4);
  endfunction

  task automatic model_edge(input bit rs, input bit ce, input bit wr, input logic [7:0] d, input bit ack);
    bit eq, eh, ei, nq, nh, set;
    if (rs) begin
      m_c = 0; m_pend = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_q = 0; m_h = 0;
      return;
    end
    nq = 0; nh = 0; set = 0;
    if (ce) begin
      if (m_pend == 1 && !wr) begin
        m_c = 0; m_pend = 0; nq = m_mode; nh = m_mode;
      end else begin
        events(m_c, m_mode, eq, eh, ei);
        nq = eq; nh = eh; set = ei;
        m_c = (m_c == (m_mode ? L5 : L4)) ? 0 : m_c + 1;
        if (m_pend > 0 && !wr) m_pend--;
      end
    end
    if (ack || (wr && d[6])) m_irq = 0;
    if (set && !m_inh) m_irq = 1;
    m_q = nq && !m_q;
    m_h = nh && !m_h;
    if (wr) begin
      m_mode = d[7]; m_inh = d[6]; m_pend = RD;
    end
  endtask

  task automatic step(input bit rs, input bit ce, input bit wr, input logic [7:0] d, input bit ack);
    @(negedge clk);
    reset = rs; cpu_ce = ce; wr_4017 = wr; wr_data = d; irq_ack = ack;
    @(posedge clk);
    model_edge(rs, ce, wr, d, ack);
    #1;
  endtask

  task automatic check_model();
    chk("quarter_frame", quarter_frame, m_q);
    chk("half_frame", half_frame, m_h);
    chk("frame_irq", frame_irq, m_irq);
    chk("mode_5step", mode_5step, m_mode);
  endtask

  initial begin
    bit ce, ack, done, stalled, wrapped;

    // ce, wr, data, ack -> q, h, irq, mode
    tbl[0]  = '{1, 0, 8'h00, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 8'h80, 0, 0, 0, 0, 1};  // 5-step write during a stall
    tbl[2]  = '{1, 0, 8'h00, 0, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 8'h00, 0, 0, 0, 0, 1};  // frozen
    tbl[4]  = '{1, 0, 8'h00, 0, 0, 0, 0, 1};
    tbl[5]  = '{1, 0, 8'h00, 0, 1, 1, 0, 1};  // delay expires: q+h
    tbl[6]  = '{1, 0, 8'h00, 0, 0, 0, 0, 1};
    tbl[7]  = '{1, 1, 8'h00, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 8'h00, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 1, 8'h40, 0, 0, 0, 0, 0};  // reload while pending
    tbl[10] = '{1, 0, 8'h00, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 0, 8'h00, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 0, 8'h00, 0, 0, 0, 0, 0};  // 4-step expiry: no pulse
    tbl[13] = '{0, 0, 8'h00, 1, 0, 0, 0, 0};

    step(1, 1, 0, 8'h00, 0);
    chk("rst_quarter", quarter_frame, 1'b0);
    chk("rst_half", half_frame, 1'b0);
    chk("rst_irq", frame_irq, 1'b0);
    chk("rst_mode", mode_5step, 1'b0);

    for (int i = 0; i < 14; i++) begin
      step(0, tbl[i].ce, tbl[i].wr, tbl[i].d, tbl[i].ack);
      chk($sformatf("tbl%0d_quarter", i), quarter_frame, tbl[i].q);
      chk($sformatf("tbl%0d_half", i), half_frame, tbl[i].h);
      chk($sformatf("tbl%0d_irq", i), frame_irq, tbl[i].irq);
      chk($sformatf("tbl%0d_mode", i), mode_5step, tbl[i].mode);
    end

    // reset while a 5-step reset is pending: no pulse, pending discarded
    step(1, 1, 0, 8'h00, 0);
    step(0, 1, 1, 8'h80, 0);
    step(0, 1, 0, 8'h00, 0);
    step(1, 1, 0, 8'h00, 0);
    chk("midrst_quarter", quarter_frame, 1'b0);
    chk("midrst_half", half_frame, 1'b0);
    chk("midrst_mode", mode_5step, 1'b0);
    for (int i = 0; i < RD + 2; i++) begin
      step(0, 1, 0, 8'h00, 0);
      chk("midrst_no_pulse", quarter_frame, 1'b0);
    end

    // 4-step frame: ack on the set edge, a stalled ack, then a 0xC0 write in frame 2
    done = 0; stalled = 0; wrapped = 0;
    for (int i = 0; i < 40000 && !done; i++) begin
      ce  = ($urandom % 16) != 0;
      ack = ce && (m_c == L4 - 1);
      if (!stalled && m_c == L4) begin
        step(0, 0, 0, 8'h00, 1);
        stalled = 1;
      end else if (wrapped && m_c == 20) begin
        step(0, 1, 1, 8'hC0, 0);
        done = 1;
      end else begin
        step(0, ce, 0, 8'h00, ack);
      end
      check_model();
      if (stalled && m_c == 0) wrapped = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL frame4_timeout: segment did not reach frame 2");
    end

    // full 5-step frame, IRQ inhibited
    for (int i = 0; i < L5 + 40; i++) begin
      step(0, 1, 0, 8'h00, 0);
      check_model();
    end

    // random mix of stalls, writes, acks and one reset
    for (int i = 0; i < 3000; i++) begin
      step(i == 1500, ($urandom % 4) != 0, ($urandom % 150) == 0, 8'($urandom), ($urandom % 40) == 0);
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
